// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver with a two-flop synchroniser and mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx_sampler #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] data,
  output logic                 Rx_valid,
  output logic                 Rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 cnt_wrap;
  logic                 par_bad;

  assign cnt_wrap = (cnt == CNT_MAX);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_bad = ^{shift, par_bit};
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data       <= '0;
      Rx_valid   <= 1'b0;
      Rx_busy    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      rx_meta    <= RX;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      Rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      cnt        <= cnt_wrap ? '0 : cnt + 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s) begin
            state   <= START;
            Rx_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              Rx_busy <= 1'b0;
            end
          end
        end

        DATA: begin
          if (cnt_wrap) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_wrap) begin
            par_bit <= rx_s;
            state   <= STOP;
          end
        end
`endif

        STOP: begin
          if (cnt_wrap) begin
            if (rx_s) begin
              state   <= IDLE;
              Rx_busy <= 1'b0;
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                data     <= shift;
                Rx_valid <= 1'b1;
              end
            end else begin
              // Line stuck low (break): park until it returns high.
              frame_err  <= 1'b1;
              parity_err <= par_bad;
              state      <= WAIT_IDLE;
            end
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state   <= IDLE;
            Rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          Rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
